// File: rtl/uart_parity_engine.sv
// uart_parity_engine: serial parity unit shared by the UART TX frame builder
// and RX deserialiser. A captured word is folded one bit per cycle into an
// XOR accumulator; the finished parity is held until the next completion and
// can be compared against a received parity bit.
module uart_parity_engine #(
  parameter int DATA_MAX = 8,
  parameter int LEN_W    = 4
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic                Data_Valid,
  input  logic [DATA_MAX-1:0] P_DATA,
  input  logic [LEN_W-1:0]    DATA_LEN,
  input  logic                PAR_EN,
  input  logic [1:0]          PAR_MODE,
  input  logic                chk_valid,
  input  logic                rx_par_bit,
  output logic                par_bit,
  output logic                par_ready,
  output logic                busy,
  output logic                par_err,
  output logic                ovr
);

  typedef enum logic {
    IDLE = 1'b0,
    CALC = 1'b1
  } state_t;

  localparam logic [LEN_W-1:0] MIN_LEN = LEN_W'(5);
  localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(DATA_MAX);
  localparam logic [LEN_W-1:0] ONE     = LEN_W'(1);

  localparam logic [1:0] MODE_EVEN  = 2'b00;
  localparam logic [1:0] MODE_ODD   = 2'b01;
  localparam logic [1:0] MODE_MARK  = 2'b10;

  // Effective word length: out-of-range requests are pinned to 5..DATA_MAX.
  function automatic logic [LEN_W-1:0] clamp_len(input logic [LEN_W-1:0] len);
    logic [LEN_W-1:0] n;
    n = len;
    if (len < MIN_LEN) n = MIN_LEN;
    else if (len > MAX_LEN) n = MAX_LEN;
    return n;
  endfunction

  // Map the raw XOR of the data bits onto the selected parity flavour.
  function automatic logic final_par(input logic acc, input logic en,
                                     input logic [1:0] mode);
    logic p;
    if (!en) p = 1'b0;
    else begin
      case (mode)
        MODE_EVEN: p = acc;
        MODE_ODD:  p = ~acc;
        MODE_MARK: p = 1'b1;
        default:   p = 1'b0;
      endcase
    end
    return p;
  endfunction

  state_t              state_q, state_d;
  logic [DATA_MAX-1:0] sreg_q, sreg_d;
  logic [LEN_W-1:0]    cnt_q, cnt_d;
  logic [LEN_W-1:0]    n_q, n_d;
  logic                acc_q, acc_d;
  logic                en_q, en_d;
  logic [1:0]          mode_q, mode_d;
  logic                par_bit_q, par_bit_d;
  logic                par_ready_q, par_ready_d;
  logic                par_err_q, par_err_d;
  logic                ovr_q, ovr_d;
  logic                fold;

  // Next-state logic: capture in IDLE, fold one bit per cycle in CALC, and
  // evaluate the parity check against the currently held result.
  always_comb begin
    state_d     = state_q;
    sreg_d      = sreg_q;
    cnt_d       = cnt_q;
    n_d         = n_q;
    acc_d       = acc_q;
    en_d        = en_q;
    mode_d      = mode_q;
    par_bit_d   = par_bit_q;
    par_ready_d = par_ready_q;
    par_err_d   = 1'b0;
    ovr_d       = 1'b0;
    fold        = acc_q ^ sreg_q[0];

    case (state_q)
      IDLE: begin
        if (Data_Valid) begin
          sreg_d      = P_DATA;
          en_d        = PAR_EN;
          mode_d      = PAR_MODE;
          n_d         = clamp_len(DATA_LEN);
          acc_d       = 1'b0;
          cnt_d       = '0;
          par_ready_d = 1'b0;
          state_d     = CALC;
        end
      end
      CALC: begin
        acc_d  = fold;
        sreg_d = sreg_q >> 1;
        cnt_d  = cnt_q + ONE;
        ovr_d  = Data_Valid;
        if (cnt_q == n_q - ONE) begin
          par_bit_d   = final_par(fold, en_q, mode_q);
          par_ready_d = 1'b1;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // Uses the pre-capture snapshot, so a check coinciding with a capture
    // still compares against the previous result.
    if (chk_valid && par_ready_q && en_q) par_err_d = rx_par_bit ^ par_bit_q;
  end

  // State and datapath registers; asynchronous reset aborts any calculation.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q     <= IDLE;
      sreg_q      <= '0;
      cnt_q       <= '0;
      n_q         <= '0;
      acc_q       <= 1'b0;
      en_q        <= 1'b0;
      mode_q      <= 2'b00;
      par_bit_q   <= 1'b0;
      par_ready_q <= 1'b0;
      par_err_q   <= 1'b0;
      ovr_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      sreg_q      <= sreg_d;
      cnt_q       <= cnt_d;
      n_q         <= n_d;
      acc_q       <= acc_d;
      en_q        <= en_d;
      mode_q      <= mode_d;
      par_bit_q   <= par_bit_d;
      par_ready_q <= par_ready_d;
      par_err_q   <= par_err_d;
      ovr_q       <= ovr_d;
    end
  end

  assign par_bit   = par_bit_q;
  assign par_ready = par_ready_q;
  assign busy      = (state_q == CALC);
  assign par_err   = par_err_q;
  assign ovr       = ovr_q;

endmodule

// File: tb/tb_uart_parity_engine.sv
// Bench for uart_parity_engine: directed scenarios with literal expectations
// followed by randomized traffic, all compared every cycle against a
// transaction-level model.
module tb_uart_parity_engine;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic       Data_Valid = 1'b0;
  logic [7:0] P_DATA = 8'h00;
  logic [3:0] DATA_LEN = 4'd0;
  logic       PAR_EN = 1'b0;
  logic [1:0] PAR_MODE = 2'b00;
  logic       chk_valid = 1'b0;
  logic       rx_par_bit = 1'b0;
  logic       par_bit, par_ready, busy, par_err, ovr;

  int n_checks = 0;
  int n_errors = 0;

  uart_parity_engine #(.DATA_MAX(8), .LEN_W(4)) dut (
    .CLK(CLK), .RST(RST), .Data_Valid(Data_Valid), .P_DATA(P_DATA),
    .DATA_LEN(DATA_LEN), .PAR_EN(PAR_EN), .PAR_MODE(PAR_MODE),
    .chk_valid(chk_valid), .rx_par_bit(rx_par_bit), .par_bit(par_bit),
    .par_ready(par_ready), .busy(busy), .par_err(par_err), .ovr(ovr)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic int eff_len(input logic [3:0] len);
    if (len < 4'd5) return 5;
    if (len > 4'd8) return 8;
    return int'(len);
  endfunction

  function automatic logic exp_par(input logic [7:0] d, input logic [3:0] len,
                                   input logic en, input logic [1:0] mode);
    int n;
    int ones;
    n = eff_len(len);
    ones = 0;
    for (int i = 0; i < n; i++) ones += int'(d[i]);
    if (!en) return 1'b0;
    case (mode)
      2'd0:    return (ones % 2) == 1;
      2'd1:    return (ones % 2) == 0;
      2'd2:    return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  logic m_busy = 0, m_ready = 0, m_par = 0, m_en = 0, m_err = 0, m_ovr = 0;
  logic m_pend = 0;
  int   m_rem = 0;

  always @(posedge CLK or negedge RST) begin
    if (!RST) begin
      m_busy <= 0; m_ready <= 0; m_par <= 0; m_en <= 0;
      m_err <= 0; m_ovr <= 0; m_pend <= 0; m_rem <= 0;
    end else begin
      m_err <= chk_valid && m_ready && m_en && (rx_par_bit ^ m_par);
      m_ovr <= Data_Valid && m_busy;
      if (m_busy) begin
        if (m_rem == 1) begin
          m_busy  <= 0;
          m_ready <= 1;
          m_par   <= m_pend;
        end
        m_rem <= m_rem - 1;
      end else if (Data_Valid) begin
        m_busy  <= 1;
        m_ready <= 0;
        m_en    <= PAR_EN;
        m_pend  <= exp_par(P_DATA, DATA_LEN, PAR_EN, PAR_MODE);
        m_rem   <= eff_len(DATA_LEN);
      end
    end
  end

  // Every-cycle comparison of all outputs against the model.
  always @(negedge CLK) begin
    check("busy", busy, m_busy);
    check("par_ready", par_ready, m_ready);
    check("par_bit", par_bit, m_par);
    check("par_err", par_err, m_err);
    check("ovr", ovr, m_ovr);
  end

  // Capture one word and measure cycles until par_ready.
  task automatic run_word(input logic [7:0] d, input logic [3:0] l, input logic e,
                          input logic [1:0] m, input int exp_lat, input logic exp_bit,
                          input string name);
    int lat;
    @(negedge CLK);
    Data_Valid = 1; P_DATA = d; DATA_LEN = l; PAR_EN = e; PAR_MODE = m;
    @(negedge CLK);
    Data_Valid = 0;
    lat = 0;
    while (!par_ready && lat < 40) begin
      @(negedge CLK);
      lat++;
    end
    check_int({name, "_latency"}, lat, exp_lat);
    check({name, "_bit"}, par_bit, exp_bit);
  endtask

  initial begin
    #2 RST = 0;
    repeat (2) @(negedge CLK);
    RST = 1;
    check("rst_busy", busy, 1'b0);
    check("rst_ready", par_ready, 1'b0);
    check("rst_par_bit", par_bit, 1'b0);
    check("rst_err", par_err, 1'b0);
    check("rst_ovr", ovr, 1'b0);

    // Pin the model with hand-computed values.
    check("model_a5_even", exp_par(8'hA5, 4'd8, 1'b1, 2'd0), 1'b0);
    check("model_f1_odd", exp_par(8'hF1, 4'd5, 1'b1, 2'd1), 1'b1);
    check("model_07_len3", exp_par(8'h07, 4'd3, 1'b1, 2'd0), 1'b1);
    check_int("model_len15", eff_len(4'd15), 8);

    // Full-width even/odd
    run_word(8'hA5, 4'd8, 1, 2'd0, 8, 1'b0, "a5_even");
    run_word(8'hA5, 4'd8, 1, 2'd1, 8, 1'b1, "a5_odd");
    // Length masking, all modes
    run_word(8'hF1, 4'd5, 1, 2'd0, 5, 1'b0, "f1_even");
    run_word(8'hF1, 4'd5, 1, 2'd1, 5, 1'b1, "f1_odd");
    run_word(8'hF1, 4'd5, 1, 2'd2, 5, 1'b1, "f1_mark");
    run_word(8'hF1, 4'd5, 1, 2'd3, 5, 1'b0, "f1_space");
    // Clamping and disable
    run_word(8'h07, 4'd3, 1, 2'd0, 5, 1'b1, "len3");
    run_word(8'hA5, 4'd15, 1, 2'd1, 8, 1'b1, "len15");
    run_word(8'h01, 4'd8, 0, 2'd1, 8, 1'b0, "disabled");

    // Overrun and config freeze
    @(negedge CLK);
    Data_Valid = 1; P_DATA = 8'h03; DATA_LEN = 4'd8; PAR_EN = 1; PAR_MODE = 2'd0;
    @(negedge CLK);
    Data_Valid = 0;
    repeat (2) @(negedge CLK);
    Data_Valid = 1; P_DATA = 8'h01; PAR_MODE = 2'd1;
    @(negedge CLK);
    Data_Valid = 0;
    check("ovr_pulse", ovr, 1'b1);
    @(negedge CLK);
    check("ovr_one_cycle", ovr, 1'b0);
    repeat (4) @(negedge CLK);
    check("ovr_word_ready", par_ready, 1'b1);
    check("ovr_word_bit", par_bit, 1'b0);

    // Parity check
    run_word(8'hA5, 4'd8, 1, 2'd1, 8, 1'b1, "chk_setup");
    @(negedge CLK);
    chk_valid = 1; rx_par_bit = 0;
    @(negedge CLK);
    chk_valid = 0;
    check("chk_mismatch", par_err, 1'b1);
    @(negedge CLK);
    check("chk_pulse_end", par_err, 1'b0);
    chk_valid = 1; rx_par_bit = 1;
    @(negedge CLK);
    chk_valid = 0;
    check("chk_match", par_err, 1'b0);
    Data_Valid = 1; P_DATA = 8'hA5; DATA_LEN = 4'd8; PAR_MODE = 2'd1;
    @(negedge CLK);
    Data_Valid = 0; chk_valid = 1; rx_par_bit = 0;
    @(negedge CLK);
    chk_valid = 0;
    check("chk_busy", par_err, 1'b0);
    repeat (8) @(negedge CLK);

    // Reset mid-calculation
    @(negedge CLK);
    Data_Valid = 1; P_DATA = 8'h5A; DATA_LEN = 4'd8; PAR_EN = 1; PAR_MODE = 2'd1;
    @(negedge CLK);
    Data_Valid = 0;
    repeat (3) @(negedge CLK);
    RST = 0;
    #1;
    check("mid_rst_busy", busy, 1'b0);
    check("mid_rst_ready", par_ready, 1'b0);
    check("mid_rst_bit", par_bit, 1'b0);
    check("mid_rst_err", par_err, 1'b0);
    check("mid_rst_ovr", ovr, 1'b0);
    @(negedge CLK);
    RST = 1;
    run_word(8'hFF, 4'd8, 1, 2'd0, 8, 1'b0, "post_rst");

    // Randomized traffic, checked by the model every cycle
    for (int i = 0; i < 3000; i++) begin
      @(negedge CLK);
      RST        = ($urandom_range(0, 499) != 0);
      Data_Valid = ($urandom_range(0, 3) == 0);
      P_DATA     = 8'($urandom);
      DATA_LEN   = 4'($urandom);
      PAR_EN     = ($urandom_range(0, 4) != 0);
      PAR_MODE   = 2'($urandom);
      chk_valid  = ($urandom_range(0, 2) == 0);
      rx_par_bit = 1'($urandom);
    end
    @(negedge CLK);
    RST = 1; Data_Valid = 0; chk_valid = 0;
    repeat (12) @(negedge CLK);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/uart_parity_engine.md
# uart_parity_engine

Parametrised, serially evaluated parity unit for the UART. It is the next-generation parity block and replaces the fixed 8-bit even/odd calculator. It captures a data word with runtime-selectable length (5..DATA_MAX bits) and computes even, odd, mark or space parity one bit per cycle to keep toggle activity low. It also checks a received parity bit against the computed result, so the TX frame builder and the RX deserialiser can share one block.

## Interface
- DATA_MAX, 8, maximum data word width in bits; must be ≥ 5.
- LEN_W, 4, width of DATA_LEN; must satisfy 2^LEN_W > DATA_MAX.
- CLK  in  1  clock; all state updates on the rising edge.
- RST  in  1  reset, asynchronous, active-low.
- Data_Valid  in  1  one-cycle strobe; captures P_DATA and the configuration.
- P_DATA  in  DATA_MAX  data word, LSB first.
- DATA_LEN  in  LEN_W  active data bits.
- PAR_EN  in  1  parity enable.
- PAR_MODE  in  2  parity mode: 00 even, 01 odd, 10 mark, 11 space.
- chk_valid  in  1  one-cycle strobe; compare rx_par_bit with the computed result.
- rx_par_bit  in  1  received parity bit.
- par_bit  out  1  computed parity bit.
- par_ready  out  1  par_bit is valid for the latest capture.
- busy  out  1  calculation in progress.
- par_err  out  1  one-cycle parity-mismatch pulse.
- ovr  out  1  one-cycle pulse: a Data_Valid was dropped.

## Operation
- **States:**
  - IDLE: no calculation running.
  - CALC: one data bit folded per cycle.
  - busy = (state == CALC).
- **Capture (IDLE with Data_Valid = 1):**
  - Latch P_DATA into the shift register.
  - Latch PAR_EN and PAR_MODE, and latch the effective length N.
  - N = 5 if DATA_LEN < 5; N = DATA_MAX if DATA_LEN > DATA_MAX; otherwise N = DATA_LEN.
  - Clear the accumulator and the bit counter, and clear par_ready.
  - Go to CALC.
- **CALC:** each cycle XOR shift-register bit[0] into the accumulator, shift right by one and increment the counter.
- **Completion:** on the cycle that folds bit N-1:
  - Load par_bit with the final value and set par_ready.
  - Go to IDLE.
- **Final value by latched mode:**
  - Even: acc.
  - Odd: ~acc.
  - Mark: 1.
  - Space: 0.
  - Latched PAR_EN = 0: par_bit = 0 regardless of mode.
- **Uniform latency:** mark, space and disabled cases still take N CALC cycles.
- **Bit masking:** bits at index ≥ N never affect the result.
- **Config changes mid-CALC:** PAR_MODE, PAR_EN and DATA_LEN changes during CALC are ignored; the captured snapshot is used.
- **Data_Valid during CALC:** the word is dropped, ovr pulses for one cycle, and the current calculation continues unaffected.
- **Check (chk_valid = 1, par_ready = 1, latched PAR_EN = 1):**
  - Next cycle par_err = rx_par_bit ^ par_bit, as a one-cycle pulse.
  - Otherwise chk_valid is ignored and par_err stays 0.
- **Simultaneous chk_valid and capturing Data_Valid in IDLE:** the check uses the old par_bit (par_ready is still 1 in that cycle), and the capture proceeds.
- **Result hold:** par_bit and par_ready hold until the next accepted capture, which clears par_ready only. par_bit keeps its old value until the next completion.

## Timing
- **Reset values:** par_bit 0, par_ready 0, busy 0, par_err 0, ovr 0, state IDLE, all internal registers 0.
- **Reset mid-CALC:** the calculation is aborted immediately with no completion.
- **Capture:** Data_Valid is sampled at edge E0; busy = 1 after E0.
- **Calculation edges:** edges E1..EN fold bits 0..N-1.
- **Completion:**
  - After EN: par_ready = 1, busy = 0, par_bit valid.
  - Latency from the capture edge to par_ready is N cycles.
- **Back-to-back captures:** the earliest next capture is at EN+1, giving a throughput of one word per N+1 cycles.
- **Check response:** par_err is asserted exactly one cycle after the accepted chk_valid edge.
- **Overrun response:** ovr is asserted one cycle after the dropped Data_Valid edge.
- **Registered outputs:** all outputs are registered with no combinational input-to-output paths.

## Test plan
- **Even/odd, full width:** DATA_MAX = 8, DATA_LEN = 8, P_DATA = 8'hA5.
  - Even -> par_bit 0 with par_ready 8 cycles after capture.
  - Odd -> par_bit 1.
  - busy is high for exactly 8 cycles.
- **Length masking and modes:** DATA_LEN = 5, P_DATA = 8'hF1 (low five bits 10001).
  - Even -> 0, odd -> 1, mark -> 1, space -> 0.
  - Latency is 5 cycles in every mode.
- **Length clamping and disable:**
  - DATA_LEN = 3, P_DATA = 8'h07, even -> par_bit 1 after 5 cycles (treated as N = 5).
  - DATA_LEN = 15 -> latency 8 cycles.
  - PAR_EN = 0, P_DATA = 8'h01, odd -> par_bit 0.
- **Overrun and config freeze:**
  - Capture 8'h03 even, DATA_LEN = 8.
  - At cycle 3 pulse Data_Valid with 8'h01 and switch PAR_MODE to odd.
  - Expect ovr pulse next cycle, then par_bit 0 at cycle 8.
- **Parity check:** after par_bit = 1 with PAR_EN = 1:
  - chk_valid with rx_par_bit = 0 -> par_err 1 for one cycle.
  - rx_par_bit = 1 -> par_err stays 0.
  - chk_valid while busy -> no par_err.
- **Reset mid-operation:**
  - Assert RST low at cycle 4 of CALC -> all outputs 0 immediately.
  - After release, a new capture of 8'hFF even, length 8 -> par_bit 0 after 8 cycles.
